// File: rtl/video_window_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_window_if
//  Purpose  : Pixel-side and memory-side signal bundle for video_window.
//  Revision : 1.0  initial release
// ============================================================================
interface video_window_if #(
    parameter int ADDR_W = 18
);
    logic [9:0]        x;
    logic [9:0]        y;
    logic [9:0]        x0;
    logic [9:0]        y0;
    logic [1:0]        mode;
    logic [7:0]        bg;
    logic [7:0]        q;
    logic [ADDR_W-1:0] address;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              in_win;

    modport master (
        output x, y, x0, y0, mode, bg, q,
        input  address, r, g, b, in_win
    );

    modport slave (
        input  x, y, x0, y0, mode, bg, q,
        output address, r, g, b, in_win
    );
endinterface
`default_nettype wire

// File: rtl/video_window.sv
`default_nettype none
// ============================================================================
//  Module   : video_window
//  Purpose  : Movable, optionally transposed/zoomed image window renderer.
//  Revision : 1.0  initial release
// ============================================================================
module video_window #(
    parameter int IMG_W   = 400,
    parameter int IMG_H   = 400,
    parameter int ADDR_W  = 18,
    parameter int MEM_LAT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    video_window_if.slave   vif
);
    localparam logic [11:0] c_img_w = 12'(IMG_W);
    localparam logic [11:0] c_img_h = 12'(IMG_H);
    localparam int          c_lin_w = 21;

    logic [9:0]         r_sx0;
    logic [9:0]         r_sy0;
    logic [1:0]         r_smode;
    logic               r_hit1;
    logic [9:0]         r_u1;
    logic [9:0]         r_v1;
    logic               r_tr1;
    logic               r_hit2;
    logic [ADDR_W-1:0]  r_address;
    logic [MEM_LAT-1:0] r_hd;
    logic [7:0]         r_pix;
    logic               r_in_win;

    logic [11:0]        w_ew;
    logic [11:0]        w_eh;
    logic [11:0]        w_xend;
    logic [11:0]        w_yend;
    logic               w_hit;
    logic [9:0]         w_dx;
    logic [9:0]         w_dy;
    logic [9:0]         w_u;
    logic [9:0]         w_v;
    logic [c_lin_w-1:0] w_lin;

    // Spans and window ends use 12 bits so origin + span can never wrap.
    always_comb begin
        w_ew   = r_smode[1] ? (c_img_w << 1) : c_img_w;
        w_eh   = r_smode[1] ? (c_img_h << 1) : c_img_h;
        w_xend = {2'b00, r_sx0} + w_ew;
        w_yend = {2'b00, r_sy0} + w_eh;
        w_hit  = (vif.x >= r_sx0) && ({2'b00, vif.x} < w_xend) &&
                 (vif.y >= r_sy0) && ({2'b00, vif.y} < w_yend);
        w_dx   = vif.x - r_sx0;
        w_dy   = vif.y - r_sy0;
        w_u    = r_smode[1] ? {1'b0, w_dx[9:1]} : w_dx;
        w_v    = r_smode[1] ? {1'b0, w_dy[9:1]} : w_dy;
    end

    always_comb begin
        if (r_tr1)
            w_lin = c_lin_w'(r_u1) * c_lin_w'(IMG_H) + c_lin_w'(r_v1);
        else
            w_lin = c_lin_w'(r_v1) * c_lin_w'(IMG_W) + c_lin_w'(r_u1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx0     <= '0;
            r_sy0     <= '0;
            r_smode   <= '0;
            r_hit1    <= 1'b0;
            r_u1      <= '0;
            r_v1      <= '0;
            r_tr1     <= 1'b0;
            r_hit2    <= 1'b0;
            r_address <= '0;
            r_hd      <= '0;
            r_pix     <= '0;
            r_in_win  <= 1'b0;
        end else begin
            // Origin/mode latch only at frame start; pixel (0,0) still sees the old values.
            if (vif.x == 10'd0 && vif.y == 10'd0) begin
                r_sx0   <= vif.x0;
                r_sy0   <= vif.y0;
                r_smode <= vif.mode;
            end
            r_hit1 <= w_hit;
            r_u1   <= w_u;
            r_v1   <= w_v;
            r_tr1  <= r_smode[0];

            r_hit2 <= r_hit1;
            if (r_hit1)
                r_address <= ADDR_W'(w_lin);

            r_hd[0] <= r_hit2;
            for (int i = 1; i < MEM_LAT; i++)
                r_hd[i] <= r_hd[i-1];

            r_in_win <= r_hd[MEM_LAT-1];
            r_pix    <= r_hd[MEM_LAT-1] ? vif.q : vif.bg;
        end
    end

    assign vif.address = r_address;
    assign vif.r       = r_pix;
    assign vif.g       = r_pix;
    assign vif.b       = r_pix;
    assign vif.in_win  = r_in_win;

endmodule
`default_nettype wire

// File: doc/video_window.md
# video_window

Parametrised image-window renderer between the VGA timing generator and the frame/image memory. For each displayed pixel it decides whether (x, y) lies inside a movable rectangular window, generates the memory read address (row-major or transposed, optional 2x zoom), aligns the returned grey sample with a configurable memory read latency, and drives r/g/b with the sample or a background level. It is the successor of the fixed-origin, fixed-size renderer used for the 400x400 image path.

## Interface

- IMG_W, 400, image width in pixels (1..1023)
- IMG_H, 400, image height in pixels (1..1023)
- ADDR_W, 18, memory address width; IMG_W*IMG_H must be at most 2^ADDR_W
- MEM_LAT, 1, memory read latency in clk cycles from address to q (1..4)

- clk  in  1  pixel clock; x/y advance once per cycle
- rst_n  in  1  asynchronous, active-low reset
- x, y  in  10 each  current screen coordinate from the timing generator
- x0, y0  in  10 each  requested window origin (top-left, screen coordinates)
- mode  in  2  bit0 = transpose (address u*IMG_H+v), bit1 = zoom 2x
- bg  in  8  grey level driven outside the window
- q  in  8  memory read data, valid MEM_LAT cycles after address
- address  out  ADDR_W  memory read address
- r, g, b  out  8 each  pixel colour
- in_win  out  1  high when r/g/b carry image data

## Operation

- Shadow registers: x0, y0, mode are sampled into sx0, sy0, smode only on the cycle with x==0 && y==0; all other cycles use the shadows. Mid-frame changes take effect next frame (no tearing).
- Stage 1 (registered): z = smode[1]; window span EW = IMG_W<<z, EH = IMG_H<<z, computed in 12 bits so x0+EW never overflows. hit = (x >= sx0) && (x < sx0+EW) && (y >= sy0) && (y < sy0+EH). u = (x-sx0)>>z, v = (y-sy0)>>z (10 bits, meaningful only when hit).
- Stage 2 (registered): if hit, address = smode[0] ? u*IMG_H+v : v*IMG_W+u, truncated to ADDR_W; if not hit, address holds its previous value.
- Alignment: hit is delayed MEM_LAT cycles through a shift register alongside the memory access.
- Output stage (registered): if delayed hit, r=g=b=q and in_win=1; else r=g=b=bg and in_win=0.
- Window parts beyond the visible screen are clipped naturally (x, y never reach them); no wrap-around of u/v.
- Reset (rst_n low, asynchronous): address=0, r=g=b=0, in_win=0, sx0=sy0=0, smode=0, stage/shift registers cleared. Output after reset release is bg-driven until the pipeline fills; hit flags are all zero so no stale q is displayed.
- Reset asserted mid-line: outputs go to reset values immediately; normal operation resumes from the first clk edge after release with the current x/y (shadows stay 0 until the next x==0 && y==0).

## Timing

- address valid 2 cycles after the x/y it corresponds to.
- r/g/b/in_win valid 3+MEM_LAT cycles after x/y (MEM_LAT=1: 4 cycles). The timing generator's sync delay must match; this is fixed and independent of mode.
- Shadow update is visible at stage 1 on the cycle after x==0 && y==0; pixel (0,0) itself uses the previous shadow values.
- No stalls or back-pressure; one pixel per cycle sustained.

## Test plan

- Defaults, x0=y0=0, mode=0, sweep (0..399, 0..399) with memory model q=address[7:0]: pixel (x=5, y=2) -> address 805 two cycles later, r=g=b=805 mod 256=37 and in_win=1 at +4 cycles; (400, 0) -> r=g=b=bg, in_win=0.
- mode=01 (transpose): (x=5, y=2) -> address 5*400+2=2002; mode=10 (zoom): (x=11, y=5) -> u=5, v=2, address 805; window spans x 0..799, clipped at 639.
- Origin move mid-frame: set x0=100 while y=200; pixels on the remaining lines still use x0=0; after the next (0,0), (x=100, y=0) -> address 0, (x=99, y=0) -> bg.
- MEM_LAT=3 build: in_win rises exactly 6 cycles after the first in-window x/y; r/g/b equal q for the matching address with no off-by-one at window left/right edges.
- Reset: assert rst_n=0 asynchronously mid-line -> address=0, r=g=b=0, in_win=0 before the next edge; after release, no in_win=1 before the pipeline refills (3+MEM_LAT cycles).
- Small parameters IMG_W=3, IMG_H=2, x0=y0=638/478: only (638..639, 478..479) hit; addresses 0, 1, 3, 4; no spurious hit from 10-bit overflow.
